// File: rtl/debounce_sync.sv
// Switch/pin debouncer: a metastability synchronizer followed by a four-state
// qualification FSM, with a saturating count of rejected level changes.
module debounce_sync #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_in,
  input  logic       en,
  output logic       data_out,
  output logic       busy,
  output logic [7:0] glitch_cnt
);

  typedef enum logic [1:0] {
    ST_LOW   = 2'd0,
    CHK_HIGH = 2'd1,
    ST_HIGH  = 2'd2,
    CHK_LOW  = 2'd3
  } state_t;

  // cnt counts qualifying samples after the one that opened the CHK state
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    sat_inc8 = (val == 8'hFF) ? val : val + 8'd1;
  endfunction

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   r_data_out;
  logic                   w_data_out_nxt;
  logic                   r_busy;
  logic                   w_busy_nxt;
  logic [7:0]             r_glitch_cnt;
  logic                   w_glitch_inc;

  // Stage 0: synchronizer, shifts every cycle independent of en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], data_in};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // Stage 1: qualification FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_LOW;
      r_cnt        <= '0;
      r_data_out   <= 1'b0;
      r_busy       <= 1'b0;
      r_glitch_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_data_out <= w_data_out_nxt;
      r_busy     <= w_busy_nxt;
      if (w_glitch_inc) begin
        r_glitch_cnt <= sat_inc8(r_glitch_cnt);
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_data_out_nxt = r_data_out;
    w_glitch_inc   = 1'b0;

    unique case (r_state)
      ST_LOW: begin
        w_data_out_nxt = 1'b0;
        if (w_s && en) begin
          w_state_nxt = CHK_HIGH;
          w_cnt_nxt   = '0;
        end
      end

      CHK_HIGH: begin
        // en abort wins over a reverting sample, so it never counts as a glitch
        if (!en) begin
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = '0;
        end else if (w_s) begin
          if (r_cnt == CNT_LAST) begin
            w_state_nxt    = ST_HIGH;
            w_data_out_nxt = 1'b1;
            w_cnt_nxt      = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end else begin
          w_state_nxt  = ST_LOW;
          w_cnt_nxt    = '0;
          w_glitch_inc = 1'b1;
        end
      end

      ST_HIGH: begin
        w_data_out_nxt = 1'b1;
        if (!w_s && en) begin
          w_state_nxt = CHK_LOW;
          w_cnt_nxt   = '0;
        end
      end

      CHK_LOW: begin
        if (!en) begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = '0;
        end else if (!w_s) begin
          if (r_cnt == CNT_LAST) begin
            w_state_nxt    = ST_LOW;
            w_data_out_nxt = 1'b0;
            w_cnt_nxt      = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end else begin
          w_state_nxt  = ST_HIGH;
          w_cnt_nxt    = '0;
          w_glitch_inc = 1'b1;
        end
      end

      default: begin
        w_state_nxt    = ST_LOW;
        w_cnt_nxt      = '0;
        w_data_out_nxt = 1'b0;
      end
    endcase

    w_busy_nxt = (w_state_nxt == CHK_HIGH) || (w_state_nxt == CHK_LOW);
  end

  assign data_out   = r_data_out;
  assign busy       = r_busy;
  assign glitch_cnt = r_glitch_cnt;

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: default and a fast (S=3, D=2) instance driven in
// parallel, each checked every cycle against a run-length reference model.
module tb_debounce_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic       data_in;
  logic       en;
  logic       dout0, busy0, dout1, busy1;
  logic [7:0] gl0, gl1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  debounce_sync u_dut_def (
    .clk(clk), .rst(rst), .data_in(data_in), .en(en),
    .data_out(dout0), .busy(busy0), .glitch_cnt(gl0)
  );

  debounce_sync #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(2), .CNT_W(4)) u_dut_small (
    .clk(clk), .rst(rst), .data_in(data_in), .en(en),
    .data_out(dout1), .busy(busy1), .glitch_cnt(gl1)
  );

  // Model: accepted level, delay line for the synchronizer, and the length of
  // the current run of samples that differ from the accepted level.
  typedef struct {
    logic [3:0] hist;
    logic       acc;
    int         run;
    int         glitch;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.hist = 4'b0; m.acc = 1'b0; m.run = 0; m.glitch = 0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, logic din, logic en_i, int S, int D);
    mdl_t n;
    logic s;
    n = m;
    s = m.hist[S-1];
    if (m.run > 0) begin
      if (!en_i) begin
        n.run = 0;
      end else if (s != m.acc) begin
        n.run = m.run + 1;
        if (n.run == D) begin
          n.acc = s;
          n.run = 0;
        end
      end else begin
        n.run = 0;
        if (m.glitch < 255) n.glitch = m.glitch + 1;
      end
    end else if (en_i && (s != m.acc)) begin
      n.run = 1;
    end
    n.hist = {m.hist[2:0], din};
    return n;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_models();
    chk("def.data_out", {7'b0, dout0}, {7'b0, m0.acc});
    chk("def.busy", {7'b0, busy0}, {7'b0, (m0.run > 0)});
    chk("def.glitch_cnt", gl0, 8'(m0.glitch));
    chk("small.data_out", {7'b0, dout1}, {7'b0, m1.acc});
    chk("small.busy", {7'b0, busy1}, {7'b0, (m1.run > 0)});
    chk("small.glitch_cnt", gl1, 8'(m1.glitch));
  endtask

  task automatic tick();
    @(posedge clk);
    m0 = mdl_step(m0, data_in, en, 2, 16);
    m1 = mdl_step(m1, data_in, en, 3, 2);
    #1;
    chk_models();
  endtask

  initial begin
    rst = 1'b1; data_in = 1'b0; en = 1'b1;
    m0 = mdl_reset(); m1 = mdl_reset();
    #3;
    chk("reset.data_out", {7'b0, dout0}, 8'd0);
    chk("reset.busy", {7'b0, busy0}, 8'd0);
    chk("reset.glitch_cnt", gl0, 8'd0);
    #9;
    rst = 1'b0;

    // Clean 0->1 step captured at edge 1
    data_in = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e == 2)  chk("step.busy_e2", {7'b0, busy0}, 8'd0);
      if (e == 3)  chk("step.busy_e3", {7'b0, busy0}, 8'd1);
      if (e == 17) chk("step.dout_e17", {7'b0, dout0}, 8'd0);
      if (e == 18) chk("step.dout_e18", {7'b0, dout0}, 8'd1);
      if (e == 4)  chk("small.dout_e4", {7'b0, dout1}, 8'd0);
      if (e == 5)  chk("small.dout_e5", {7'b0, dout1}, 8'd1);
    end
    chk("step.glitch_cnt", gl0, 8'd0);

    // Falling qualification aborted by en on the 8th CHK_LOW cycle
    data_in = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("abort.busy_before", {7'b0, busy0}, 8'd1);
    en = 1'b0;
    tick();
    chk("abort.busy", {7'b0, busy0}, 8'd0);
    chk("abort.data_out", {7'b0, dout0}, 8'd1);
    chk("abort.glitch_cnt", gl0, 8'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("hold.data_out", {7'b0, dout0}, 8'd1);
    en = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (e == 1)  chk("reen.busy_e1", {7'b0, busy0}, 8'd1);
      if (e == 15) chk("reen.dout_e15", {7'b0, dout0}, 8'd1);
      if (e == 16) chk("reen.dout_e16", {7'b0, dout0}, 8'd0);
    end
    for (int i = 0; i < 4; i++) tick();

    // High 5, low 1, then high: one rejected candidate
    data_in = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    data_in = 1'b0;
    tick();
    data_in = 1'b1;
    for (int e = 1; e <= 25; e++) begin
      tick();
      if (e == 5) chk("glitch1.dout_mid", {7'b0, dout0}, 8'd0);
    end
    chk("glitch1.glitch_cnt", gl0, 8'd1);
    chk("glitch1.dout_final", {7'b0, dout0}, 8'd1);
    data_in = 1'b0;
    for (int i = 0; i < 25; i++) tick();

    // Asynchronous reset pulse between edges in CHK_HIGH
    data_in = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    m0 = mdl_reset(); m1 = mdl_reset();
    chk("arst.data_out", {7'b0, dout0}, 8'd0);
    chk("arst.busy", {7'b0, busy0}, 8'd0);
    chk("arst.glitch_cnt", gl0, 8'd0);
    chk_models();
    #2;
    rst = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e == 17) chk("arst.dout_e17", {7'b0, dout0}, 8'd0);
      if (e == 18) chk("arst.dout_e18", {7'b0, dout0}, 8'd1);
    end
    data_in = 1'b0;
    for (int i = 0; i < 25; i++) tick();

    // 300 short pulses saturate the glitch counter
    for (int p = 0; p < 300; p++) begin
      data_in = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      data_in = 1'b0;
      for (int i = 0; i < 3; i++) tick();
    end
    chk("sat.glitch_cnt", gl0, 8'd255);
    chk("sat.data_out", {7'b0, dout0}, 8'd0);

    // Randomized holds and enable drops
    for (int r = 0; r < 150; r++) begin
      int hold;
      hold    = int'($urandom_range(1, 24));
      data_in = 1'($urandom_range(0, 1));
      en      = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < hold; i++) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
